// File: rtl/nibble_serial_add_if.sv
// Operand/result handshake bundle for the nibble-serial add/subtract controller.
// Producer and consumer both use valid/ready: a transfer happens on a rising edge where both are high.
interface nibble_serial_add_if #(
    parameter int NIBBLES = 4
) ();
    localparam int WIDTH = 4 * NIBBLES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output in_valid, op_a, op_b, sub, out_ready,
        input  in_ready, out_valid, result, c_out, overflow, busy, dbg_state
    );

    modport slave (
        input  in_valid, op_a, op_b, sub, out_ready,
        output in_ready, out_valid, result, c_out, overflow, busy, dbg_state
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract built from one shared 4-bit adder slice, one nibble per cycle, LSB first.
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_add_if.slave bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IW    = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic [IW-1:0]    r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_c_out;
    logic             r_overflow;
    logic             r_busy;

    logic [3:0]       w_slice_a;
    logic [3:0]       w_slice_b;
    logic [3:0]       w_slice_sum;
    logic             w_slice_co;

    // The only adder in the block: subtraction is A + ~B + 1, the +1 entering as the initial carry.
    always_comb begin
        w_slice_a = r_a[4*r_idx +: 4];
        w_slice_b = r_b[4*r_idx +: 4] ^ {4{r_sub}};
        {w_slice_co, w_slice_sum} = {1'b0, w_slice_a} + {1'b0, w_slice_b} + {4'b0000, r_carry};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sub       <= 1'b0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_c_out     <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.op_a;
                        r_b        <= bus.op_b;
                        r_sub      <= bus.sub;
                        r_idx      <= '0;
                        r_carry    <= bus.sub;
                        r_result   <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[4*r_idx +: 4] <= w_slice_sum;
                    r_carry                <= w_slice_co;
                    if (r_idx == LAST_IDX) begin
                        // Index parked at 0 so it never points past the operand outside RUN.
                        r_idx       <= '0;
                        r_c_out     <= w_slice_co;
                        r_overflow  <= ~(w_slice_a[3] ^ w_slice_b[3]) & (w_slice_sum[3] ^ w_slice_a[3]);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.c_out     = r_c_out;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: a 4-nibble and a 2-nibble instance checked against an
// arithmetic reference model through expected-result queues popped by per-instance monitors.
`timescale 1ns/1ps
module tb_nibble_serial_add_ctrl;
    localparam int N4 = 4;
    localparam int N2 = 2;
    localparam int W4 = 16;
    localparam int W2 = 8;
    localparam int EW = 18;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_add_if #(.NIBBLES(N4)) bus4 ();
    nibble_serial_add_if #(.NIBBLES(N2)) bus2 ();

    nibble_serial_add_ctrl #(.NIBBLES(N4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    nibble_serial_add_ctrl #(.NIBBLES(N2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required at t=%0t", name, $time);
    endtask

    // Reference: plain integer arithmetic, packed as {c_out, overflow, result[15:0]}.
    function automatic logic [EW-1:0] model(input int w, input longint a, input longint b, input bit s);
        longint m, h, sa, sb, r, sr;
        logic c, ov;
        logic [15:0] res;
        m  = longint'(1) << w;
        h  = m / 2;
        sa = (a >= h) ? a - m : a;
        sb = (b >= h) ? b - m : b;
        if (s) begin
            r = a - b; sr = sa - sb; c = (a >= b);
        end else begin
            r = a + b; sr = sa + sb; c = (r >= m);
        end
        r   = ((r % m) + m) % m;
        res = 16'(r);
        ov  = (sr >= h) || (sr < -h);
        return {c, ov, res};
    endfunction

    // ---------------- scoreboards and monitors ----------------
    logic [EW-1:0] exp4_q[$];
    logic [EW-1:0] exp2_q[$];
    int            acc4_q[$];
    logic [EW-1:0] e4, e2;
    logic          prev_ov4 = 1'b0;
    int            prev_acc4 = -1;
    int            prev_acc2 = -1;
    bit            chk_spc4 = 1'b0;
    bit            chk_spc2 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus4.in_valid && bus4.in_ready) begin
                if (chk_spc4 && prev_acc4 >= 0) check("spacing4", cyc + 1 - prev_acc4, N4 + 2);
                prev_acc4 = cyc + 1;
                acc4_q.push_back(cyc + 1);
            end
            if (bus4.out_valid && !prev_ov4) begin
                if (acc4_q.size() == 0) fail_event("latency4_no_accept");
                else check("latency4", cyc - acc4_q.pop_front(), N4);
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (exp4_q.size() == 0) fail_event("unexpected_out4");
                else begin
                    e4 = exp4_q.pop_front();
                    check("result4", bus4.result, e4[15:0]);
                    check("c_out4", bus4.c_out, e4[17]);
                    check("overflow4", bus4.overflow, e4[16]);
                end
            end
        end
        prev_ov4 = bus4.out_valid;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus2.in_valid && bus2.in_ready) begin
                if (chk_spc2 && prev_acc2 >= 0) check("spacing2", cyc + 1 - prev_acc2, N2 + 2);
                prev_acc2 = cyc + 1;
            end
            if (bus2.out_valid && bus2.out_ready) begin
                if (exp2_q.size() == 0) fail_event("unexpected_out2");
                else begin
                    e2 = exp2_q.pop_front();
                    check("result2", bus2.result, e2[7:0]);
                    check("c_out2", bus2.c_out, e2[17]);
                    check("overflow2", bus2.overflow, e2[16]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic s);
        bit acc = 1'b0;
        bus4.op_a = a; bus4.op_b = b; bus4.sub = s; bus4.in_valid = 1'b1;
        exp4_q.push_back(model(W4, a, b, s));
        for (int k = 0; k < 50; k++) begin
            acc = bus4.in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) fail_event("accept_timeout4");
    endtask

    task automatic issue2(input logic [7:0] a, input logic [7:0] b, input logic s);
        bit acc = 1'b0;
        bus2.op_a = a; bus2.op_b = b; bus2.sub = s; bus2.in_valid = 1'b1;
        exp2_q.push_back(model(W2, a, b, s));
        for (int k = 0; k < 50; k++) begin
            acc = bus2.in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        if (!acc) fail_event("accept_timeout2");
    endtask

    task automatic drain4();
        for (int k = 0; k < 100 && exp4_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (exp4_q.size() != 0) fail_event("drain_timeout4");
    endtask

    task automatic drain2();
        for (int k = 0; k < 100 && exp2_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (exp2_q.size() != 0) fail_event("drain_timeout2");
    endtask

    // ---------------- stimulus ----------------
    logic [15:0]   dir_a[8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0000, 16'hFFFF, 16'h8000};
    logic [15:0]   dir_b[8] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000};
    logic          dir_s[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [EW-1:0] bp_exp;
    bit            seen;

    initial begin
        rst = 1'b1;
        bus4.in_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.op_a = '0; bus2.op_b = '0; bus2.sub = 1'b0; bus2.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", bus4.in_ready, 1);
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_result", bus4.result, 0);
        check("rst_c_out", bus4.c_out, 0);
        check("rst_overflow", bus4.overflow, 0);
        check("rst_busy", bus4.busy, 0);
        check("rst_state", bus4.dbg_state, 0);
        rst = 1'b0;

        // directed corner operations
        for (int i = 0; i < 8; i++) begin
            issue4(dir_a[i], dir_b[i], dir_s[i]);
            bus4.in_valid = 1'b0;
            drain4();
        end

        // backpressure in DONE with operand churn during RUN
        bus4.out_ready = 1'b0;
        bp_exp = model(W4, 16'h1234, 16'h5678, 1'b1);
        issue4(16'h1234, 16'h5678, 1'b1);
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus4.op_a = 16'($urandom); bus4.op_b = 16'($urandom); bus4.sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus4.out_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!seen) fail_event("bp_out_valid_timeout");
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", bus4.out_valid, 1);
            check("bp_result", bus4.result, bp_exp[15:0]);
            check("bp_in_ready", bus4.in_ready, 0);
            @(posedge clk); #1;
        end
        bus4.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", bus4.in_ready, 1);
        check("bp_release_out_valid", bus4.out_valid, 0);
        check("bp_release_state", bus4.dbg_state, 0);
        check("bp_release_busy", bus4.busy, 0);

        // reset in the middle of RUN
        issue4(16'h4321, 16'h1111, 1'b0);
        bus4.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("mid_run_state", bus4.dbg_state, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_state", bus4.dbg_state, 0);
        check("mid_rst_in_ready", bus4.in_ready, 1);
        check("mid_rst_out_valid", bus4.out_valid, 0);
        check("mid_rst_result", bus4.result, 0);
        rst = 1'b0;
        exp4_q.delete();
        acc4_q.delete();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("post_rst_no_valid", bus4.out_valid, 0);
        end
        issue4(16'h0001, 16'h0001, 1'b0);
        bus4.in_valid = 1'b0;
        drain4();

        // streaming, 4 nibbles
        prev_acc4 = -1;
        chk_spc4 = 1'b1;
        for (int i = 0; i < 200; i++)
            issue4(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        bus4.in_valid = 1'b0;
        drain4();
        chk_spc4 = 1'b0;

        // streaming, 2 nibbles, corner cases first
        prev_acc2 = -1;
        chk_spc2 = 1'b1;
        issue2(8'hFF, 8'h01, 1'b0);
        issue2(8'h7F, 8'h01, 1'b0);
        issue2(8'h80, 8'h01, 1'b1);
        issue2(8'h05, 8'h07, 1'b1);
        for (int i = 0; i < 200; i++)
            issue2(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        bus2.in_valid = 1'b0;
        drain2();
        chk_spc2 = 1'b0;

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that performs a WIDTH = 4*NIBBLES bit add or subtract by time-multiplexing one shared 4-bit adder slice (4-bit a/b, c_in, sum, c_out), one nibble per cycle, LSB nibble first.
- Serves area-constrained paths where a full-width adder is not justified.
- Sits between a valid/ready operand producer and a valid/ready result consumer.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; WIDTH = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- sub  input  1  0: A+B; 1: A-B
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  sum or difference, modulo 2^WIDTH
- c_out  output  1  final carry; for sub, 1 = no borrow (A >= B unsigned)
- overflow  output  1  two's-complement signed overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- One clock domain, one reset. Reset is synchronous and active-high: rst sampled high at a clk rising edge resets the block.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, c_out=0, overflow=0, busy=0, nibble index=0, carry register=0.
- rst has priority over all other inputs. Reset mid-RUN or mid-DONE discards the operation; no out_valid pulse follows.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch op_a, op_b, sub; idx<=0; carry<=sub; clear result; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle the slice receives a = A[4*idx+:4], b = B[4*idx+:4] XOR {4{sub}}, c_in = carry.
  - At the edge, result[4*idx+:4]<=sum; carry<=slice c_out; idx<=idx+1.
  - On the edge where idx==NIBBLES-1:
    - c_out <= slice c_out;
    - overflow <= (a[3] XNOR b'[3]) AND (sum[3] XOR a[3]), where b' is the inverted-when-sub operand and a, b', sum are the MSB-nibble values;
    - go to DONE.
- DONE:
  - out_valid=1; result, c_out and overflow are stable.
  - On an edge with out_ready=1: out_valid<=0; go to IDLE.
  - Holds indefinitely while out_ready=0.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge.
- Minimum initiation interval is NIBBLES+2 cycles, since in_ready only returns in IDLE. in_valid may be asserted during DONE, but acceptance waits until IDLE.
- result, c_out and overflow hold their last values in IDLE until the next operation overwrites them. Partial nibbles of result are visible during RUN and are not valid data.
- Operand registers are captured at acceptance; later changes on op_a, op_b or sub have no effect.
- Implementation must use a single 4-bit adder slice; no WIDTH-bit adder is permitted.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FFF -> out_valid exactly 4 cycles after acceptance; result=0x2233, c_out=0, overflow=0.
- Add 0xFFFF+0x0001 -> result=0x0000, c_out=1, overflow=0 (carry ripples through all 4 nibble cycles). Add 0x7FFF+0x0001 -> result=0x8000, c_out=0, overflow=1.
- Sub 0x0005-0x0007 -> result=0xFFFE, c_out=0, overflow=0. Sub 0x8000-0x0001 -> result=0x7FFF, c_out=1, overflow=1.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and result held constant, in_ready=0. Drive op_a changes during RUN -> result unaffected. Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset: assert rst during RUN (idx=2) -> next edge state=IDLE, in_ready=1, out_valid=0, result=0; no out_valid appears over the following 8 cycles. A new op 0x0001+0x0001 then gives result=0x0002.
- Back-to-back: in_valid held high with random operands, out_ready=1, 200 ops vs. reference model -> all results, c_out and overflow match; spacing between accepts is 6 cycles. Repeat with NIBBLES=2.
